// File: rtl/axi_dma_pkg.sv
// ---------------------------------------------------------------------------
// axi_dma_pkg
// Shared definitions for the AXI write DMA: FSM state encoding, the AXI
// burst/response/cache constants driven on the write channels, and the
// 4 KiB boundary that no AXI burst may cross.
// ---------------------------------------------------------------------------
package axi_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } dma_state_t;

    localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    // Normal non-cacheable bufferable memory.
    localparam logic [3:0]  AXI_CACHE_NC_BUF = 4'b0011;
    localparam int unsigned BOUNDARY_4K      = 4096;

endpackage

// File: rtl/axi_dma_burst_calc.sv
// ---------------------------------------------------------------------------
// axi_dma_burst_calc
// Combinational burst sizing. The burst length is the smallest of:
// the beats still owed by the command, MAX_BURST_LEN, and the beats left
// before the next 4 KiB boundary.
//
// Ports:
//   addr      in  ADDR_WIDTH  burst start byte address (beat aligned)
//   remaining in  LEN_WIDTH   beats still to be written for the command
//   beats     out 9           beats in the next burst (1..256)
// ---------------------------------------------------------------------------
module axi_dma_burst_calc
    import axi_dma_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16,
    parameter int SIZE          = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [8:0]            beats
);

    // Common compare width wide enough for both the length and the
    // 13-bit byte distance to the boundary.
    localparam int CW = ((LEN_WIDTH > 13) ? LEN_WIDTH : 13) + 1;

    logic [ADDR_WIDTH+11:0] w_addr_ext;
    logic [12:0]            w_to_4k_bytes;
    logic [CW-1:0]          w_to_4k;
    logic [CW-1:0]          w_rem;
    logic [CW-1:0]          w_max;
    logic [CW-1:0]          w_min_a;
    logic [CW-1:0]          w_min;
    logic                   w_unused_bits;

    // Zero-extend so the page offset is available for any address width.
    assign w_addr_ext    = {12'd0, addr};
    // Address is beat aligned, so this is always at least one beat.
    assign w_to_4k_bytes = 13'(BOUNDARY_4K) - {1'b0, w_addr_ext[11:0]};
    assign w_to_4k       = CW'(w_to_4k_bytes >> SIZE);
    assign w_rem         = CW'(remaining);
    assign w_max         = CW'(MAX_BURST_LEN);

    assign w_min_a = (w_rem < w_max) ? w_rem : w_max;
    assign w_min   = (w_to_4k < w_min_a) ? w_to_4k : w_min_a;

    // Bounded by MAX_BURST_LEN (<= 256), so nine bits hold the result.
    assign beats = w_min[8:0];

    assign w_unused_bits = ^{w_addr_ext[ADDR_WIDTH+11:12], w_min[CW-1:9]};

endmodule

// File: rtl/axi_dma_wr.sv
// ---------------------------------------------------------------------------
// axi_dma_wr
// Stream-to-memory write DMA. A command (start address, beat count) is
// split into AXI4 INCR bursts that never exceed MAX_BURST_LEN nor cross a
// 4 KiB boundary. One burst is outstanding at a time: AW, then W beats
// taken straight from the input stream, then the B response. Any SLVERR /
// DECERR response is accumulated and reported with the completion pulse.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_addr/cmd_len/cmd_valid    command in (byte address, beat count)
//   cmd_ready                     high while idle
//   s_axis_tdata/tvalid/tready    write-data stream
//   m_axi_aw*                     AXI4 write address channel (master)
//   m_axi_w*                      AXI4 write data channel (master)
//   m_axi_b*                      AXI4 write response channel (master)
//   status_done                   one-cycle pulse at command completion
//   status_error                  error flag, valid with status_done
// ---------------------------------------------------------------------------
module axi_dma_wr
    import axi_dma_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int ID_WIDTH      = 8,
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,

    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,

    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic                      status_done,
    output logic                      status_error
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    dma_state_t             r_state;
    dma_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  w_addr_nxt;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [LEN_WIDTH-1:0]   w_rem_nxt;
    logic [8:0]             r_burst_cnt;
    logic [8:0]             w_burst_nxt;
    logic [8:0]             r_beats;
    logic [8:0]             w_beats;
    logic                   r_awvalid;
    logic                   r_bready;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   r_error;
    logic                   w_error_nxt;
    logic                   r_err_acc;
    logic                   w_err_acc_nxt;
    logic                   w_beat_acc;
    logic                   w_enter_addr;
    logic                   w_unused_bits;

    assign w_beat_acc   = (r_state == ST_DATA) && s_axis_tvalid && m_axi_wready;
    // Burst size is fixed on every transition into ADDR, from IDLE or RESP.
    assign w_enter_addr = (w_state_nxt == ST_ADDR) && (r_state != ST_ADDR);

    // Sized from the values the registers are about to take, so the
    // length is ready in the same cycle awvalid rises.
    axi_dma_burst_calc #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .SIZE          (SIZE)
    ) u_burst_calc (
        .addr      (w_addr_nxt),
        .remaining (w_rem_nxt),
        .beats     (w_beats)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_rem_nxt     = r_remaining;
        w_burst_nxt   = r_burst_cnt;
        w_err_acc_nxt = r_err_acc;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_addr_nxt    = cmd_addr & ~ALIGN_MASK;
                    w_rem_nxt     = cmd_len;
                    w_err_acc_nxt = 1'b0;
                    if (cmd_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (m_axi_awready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_beat_acc) begin
                    w_rem_nxt   = r_remaining - LEN_WIDTH'(1);
                    w_burst_nxt = r_burst_cnt - 9'd1;
                    if (r_burst_cnt == 9'd1) begin
                        w_state_nxt = ST_RESP;
                        // Wraps modulo 2^ADDR_WIDTH by construction.
                        w_addr_nxt  = r_addr + (ADDR_WIDTH'(r_beats) << SIZE);
                    end
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid && r_bready) begin
                    // bresp[1] set means SLVERR or DECERR.
                    w_err_acc_nxt = r_err_acc | m_axi_bresp[1];
                    if (r_remaining != '0) begin
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_error_nxt = r_err_acc | m_axi_bresp[1];
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_burst_cnt <= '0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_acc   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_rem_nxt;
            r_burst_cnt <= w_enter_addr ? w_beats : w_burst_nxt;
            r_awvalid   <= (w_state_nxt == ST_ADDR);
            r_bready    <= (w_state_nxt == ST_RESP);
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_err_acc   <= w_err_acc_nxt;
        end
    end

    // Address datapath; only meaningful while a command is active.
    always_ff @(posedge clk) begin
        r_addr <= w_addr_nxt;
        if (w_enter_addr) begin
            r_beats <= w_beats;
        end
    end

    // Output decode
    always_comb begin
        cmd_ready     = (r_state == ST_IDLE);

        m_axi_awid    = '0;
        m_axi_awaddr  = r_addr;
        m_axi_awlen   = 8'(r_beats - 9'd1);
        m_axi_awsize  = 3'(SIZE);
        m_axi_awburst = AXI_BURST_INCR;
        m_axi_awlock  = 1'b0;
        m_axi_awcache = AXI_CACHE_NC_BUF;
        m_axi_awprot  = '0;
        m_axi_awvalid = r_awvalid;

        // The W channel is a gated pass-through of the stream.
        m_axi_wdata   = (r_state == ST_DATA) ? s_axis_tdata : '0;
        m_axi_wstrb   = '1;
        m_axi_wvalid  = (r_state == ST_DATA) && s_axis_tvalid;
        m_axi_wlast   = (r_state == ST_DATA) && (r_burst_cnt == 9'd1);
        s_axis_tready = (r_state == ST_DATA) && m_axi_wready;

        m_axi_bready  = r_bready;
        status_done   = r_done;
        status_error  = r_error;
    end

    assign w_unused_bits = ^{m_axi_bid, m_axi_bresp[0]};

endmodule

// File: tb/tb_axi_dma_wr.sv
// ---------------------------------------------------------------------------
// tb_axi_dma_wr
// Directed bench for axi_dma_wr with a 64 KiB AXI RAM slave model and a
// stream source, both with optional random handshake stalls.
// ---------------------------------------------------------------------------
module tb_axi_dma_wr;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int IW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [IW-1:0] m_axi_awid;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awlock;
    logic [3:0]    m_axi_awcache;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [IW-1:0] m_axi_bid = '0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic          status_done;
    logic          status_error;

    axi_dma_wr #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .ID_WIDTH      (IW),
        .LEN_WIDTH     (LW),
        .MAX_BURST_LEN (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awlock  (m_axi_awlock),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .status_done   (status_done),
        .status_error  (status_error)
    );

    always #5 clk = ~clk;

    // Scoreboard counters
    int n_checks = 0;
    int n_fail   = 0;

    // Slave / monitor state (written only by the posedge monitor)
    logic [31:0] mem [0:16383];
    logic [15:0] aw_addr_log[$];
    logic [7:0]  aw_len_log[$];
    logic [15:0] cur_addr = '0;
    int          cur_len  = 0;
    int          cur_beat = 0;
    bit          b_pend   = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0;
    int          wlast_err = 0, attr_err = 0;
    logic        last_err = 1'b0;
    int          src_idx = 0;

    // Stimulus state (written only by the main initial block)
    logic [31:0] src_data [0:255];
    int          src_len   = 0;
    bit          stall     = 1'b0;
    int          err_burst = -1;

    // Driver-private
    int          prev_idx = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit rnd();
        return stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Monitor and RAM slave: observe handshakes on the active edge.
    always @(posedge clk) begin
        if (status_done) begin
            done_cnt = done_cnt + 1;
            last_err = status_error;
        end
        if (rst) begin
            b_pend   = 1'b0;
            cur_beat = 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log.push_back(m_axi_awaddr);
                aw_len_log.push_back(m_axi_awlen);
                if (m_axi_awsize != 3'd2 || m_axi_awburst != 2'b01 || m_axi_awcache != 4'b0011 ||
                    m_axi_awid != '0 || m_axi_awlock != 1'b0 || m_axi_awprot != 3'd0)
                    attr_err = attr_err + 1;
                cur_addr = m_axi_awaddr;
                cur_len  = int'(m_axi_awlen);
                cur_beat = 0;
                aw_cnt   = aw_cnt + 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                mem[cur_addr[15:2]] = m_axi_wdata;
                if (m_axi_wlast !== (cur_beat == cur_len)) wlast_err = wlast_err + 1;
                if (m_axi_wstrb !== 4'hF) attr_err = attr_err + 1;
                if (cur_beat == cur_len) b_pend = 1'b1;
                cur_beat = cur_beat + 1;
                cur_addr = cur_addr + 16'd4;
                w_cnt    = w_cnt + 1;
            end
            if (s_axis_tvalid && s_axis_tready) src_idx = src_idx + 1;
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend = 1'b0;
                b_cnt  = b_cnt + 1;
            end
        end
    end

    // Drivers for slave responses and stream source, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            s_axis_tvalid = 1'b0;
        end else begin
            m_axi_awready = rnd();
            m_axi_wready  = rnd();
            m_axi_bvalid  = b_pend && (m_axi_bvalid || rnd());
            m_axi_bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
            s_axis_tvalid = (src_idx < src_len) &&
                            ((s_axis_tvalid && (src_idx == prev_idx)) || rnd());
            s_axis_tdata  = src_data[src_idx % 256];
        end
        prev_idx = src_idx;
    end

    task automatic push_src(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            src_data[src_len % 256] = base + 32'(i);
            src_len = src_len + 1;
        end
    endtask

    task automatic issue_cmd(input string tag, input logic [15:0] a, input logic [15:0] l);
        @(negedge clk);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int start_done);
        int n;
        n = 0;
        while (done_cnt == start_done && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check_eq({tag, "_done"}, 32'(done_cnt - start_done), 32'd1);
    endtask

    task automatic check_burst(input string tag, input int idx, input logic [15:0] ea, input logic [7:0] el);
        logic [31:0] ga, gl;
        ga = (idx < aw_addr_log.size()) ? 32'(aw_addr_log[idx]) : 32'hDEAD_BEEF;
        gl = (idx < aw_len_log.size())  ? 32'(aw_len_log[idx])  : 32'hDEAD_BEEF;
        check_eq({tag, "_awaddr"}, ga, 32'(ea));
        check_eq({tag, "_awlen"},  gl, 32'(el));
    endtask

    task automatic check_words(input string tag, input int word0, input int n, input logic [31:0] base);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (mem[(word0 + i) % 16384] !== base + 32'(i)) bad++;
        check_eq({tag, "_bad_words"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, w0, b0, d0, n;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
        check_eq("rst_bready",  32'(m_axi_bready),  32'd0);
        check_eq("rst_done",    32'(status_done),   32'd0);
        check_eq("rst_error",   32'(status_error),  32'd0);
        check_eq("rst_tready",  32'(s_axis_tready), 32'd0);
        check_eq("rst_wvalid",  32'(m_axi_wvalid),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_cmd_ready_after_release", 32'(cmd_ready), 32'd1);

        // T1: 0x0100, 4 beats, single burst
        a0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
        push_src(4, 32'd1);
        issue_cmd("t1", 16'h0100, 16'd4);
        wait_done("t1", d0);
        check_eq("t1_aw_count", 32'(aw_cnt - a0), 32'd1);
        check_burst("t1_b0", a0, 16'h0100, 8'd3);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t1_mem%0d", i), mem[16'h40 + i], 32'(i + 1));
        check_eq("t1_w_count", 32'(w_cnt - w0), 32'd4);
        check_eq("t1_error", 32'(last_err), 32'd0);

        // T2: 0x0000, 40 beats -> 16/16/8
        a0 = aw_cnt; d0 = done_cnt;
        push_src(40, 32'h1000);
        issue_cmd("t2", 16'h0000, 16'd40);
        wait_done("t2", d0);
        check_eq("t2_aw_count", 32'(aw_cnt - a0), 32'd3);
        check_burst("t2_b0", a0,     16'h0000, 8'd15);
        check_burst("t2_b1", a0 + 1, 16'h0040, 8'd15);
        check_burst("t2_b2", a0 + 2, 16'h0080, 8'd7);
        check_words("t2", 0, 40, 32'h1000);
        check_eq("t2_error", 32'(last_err), 32'd0);

        // T3: 0x0FF8, 4 beats -> split at the 4 KiB boundary
        a0 = aw_cnt; d0 = done_cnt;
        push_src(4, 32'h2000);
        issue_cmd("t3", 16'h0FF8, 16'd4);
        wait_done("t3", d0);
        check_eq("t3_aw_count", 32'(aw_cnt - a0), 32'd2);
        check_burst("t3_b0", a0,     16'h0FF8, 8'd1);
        check_burst("t3_b1", a0 + 1, 16'h1000, 8'd1);
        check_words("t3", 16'h3FE, 4, 32'h2000);

        // T3b: unaligned start address is rounded down to a beat
        a0 = aw_cnt; d0 = done_cnt;
        push_src(2, 32'h2100);
        issue_cmd("t3b", 16'h0203, 16'd2);
        wait_done("t3b", d0);
        check_burst("t3b_b0", a0, 16'h0200, 8'd1);
        check_words("t3b", 16'h80, 2, 32'h2100);

        // T4: zero-length command
        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 16'h0500;
        cmd_len   = 16'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_eq("t4_done_pulse",  32'(status_done),  32'd1);
        check_eq("t4_done_error",  32'(status_error), 32'd0);
        check_eq("t4_stays_idle",  32'(cmd_ready),    32'd1);
        @(posedge clk);
        #1;
        check_eq("t4_done_one_cycle", 32'(status_done), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("t4_no_aw", 32'(aw_cnt - a0), 32'd0);
        check_eq("t4_no_w",  32'(w_cnt - w0),  32'd0);
        check_eq("t4_no_b",  32'(b_cnt - b0),  32'd0);
        check_eq("t4_done_count", 32'(done_cnt - d0), 32'd1);

        // T5: random stalls, 37 beats from 0x2FF0, third burst answers SLVERR
        stall = 1'b1;
        a0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
        wlast_err = wlast_err;
        n = wlast_err;
        err_burst = b_cnt + 2;
        push_src(37, 32'h3000);
        issue_cmd("t5", 16'h2FF0, 16'd37);
        wait_done("t5", d0);
        check_eq("t5_aw_count", 32'(aw_cnt - a0), 32'd4);
        check_burst("t5_b0", a0,     16'h2FF0, 8'd3);
        check_burst("t5_b1", a0 + 1, 16'h3000, 8'd15);
        check_burst("t5_b2", a0 + 2, 16'h3040, 8'd15);
        check_burst("t5_b3", a0 + 3, 16'h3080, 8'd0);
        check_words("t5", 16'hBFC, 37, 32'h3000);
        check_eq("t5_w_count", 32'(w_cnt - w0), 32'd37);
        check_eq("t5_wlast_errors", 32'(wlast_err - n), 32'd0);
        check_eq("t5_error", 32'(last_err), 32'd1);

        // T6: next command clears the error accumulator (stalls kept on)
        err_burst = -1;
        d0 = done_cnt;
        push_src(3, 32'h4000);
        issue_cmd("t6", 16'h0600, 16'd3);
        wait_done("t6", d0);
        check_words("t6", 16'h180, 3, 32'h4000);
        check_eq("t6_error", 32'(last_err), 32'd0);

        // T7: reset in the middle of a burst
        stall = 1'b0;
        w0 = w_cnt; d0 = done_cnt;
        push_src(8, 32'h5000);
        issue_cmd("t7", 16'h0700, 16'd8);
        n = 0;
        while ((w_cnt - w0) < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t7_reached_mid_burst", 32'((w_cnt - w0) >= 3), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        src_len = src_idx;
        check_eq("t7_awvalid", 32'(m_axi_awvalid), 32'd0);
        check_eq("t7_tready",  32'(s_axis_tready), 32'd0);
        check_eq("t7_wvalid",  32'(m_axi_wvalid),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t7_cmd_ready_after_release", 32'(cmd_ready), 32'd1);
        repeat (5) @(negedge clk);
        check_eq("t7_no_done", 32'(done_cnt - d0), 32'd0);

        // T8: DMA is usable again after the abandoned command
        a0 = aw_cnt; d0 = done_cnt;
        push_src(2, 32'h6000);
        issue_cmd("t8", 16'h0800, 16'd2);
        wait_done("t8", d0);
        check_burst("t8_b0", a0, 16'h0800, 8'd1);
        check_words("t8", 16'h200, 2, 32'h6000);
        check_eq("t8_error", 32'(last_err), 32'd0);

        check_eq("aw_w_attributes", 32'(attr_err), 32'd0);
        check_eq("wlast_errors_total", 32'(wlast_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
